// File: rtl/pe_array_feeder.sv
// Upstream feeder for a weight-stationary PE chain: serial weight load, one-shot
// weight strobe, then diagonally skewed window streaming with an aligned valid tag.
module pe_array_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PE     = 9,
  parameter int WORD_SIZE  = DATA_WIDTH * NUM_PE,
  parameter int PE_LAT     = 1
) (
  input  logic                 iClk,
  input  logic                 iRest,
  input  logic                 iStart,
  input  logic                 iW_valid,
  input  logic [DATA_WIDTH-1:0] iW_data,
  output logic                 oW_ready,
  input  logic                 iX_valid,
  input  logic [WORD_SIZE-1:0] iX_data,
  input  logic                 iX_last,
  output logic                 oX_ready,
  output logic [WORD_SIZE-1:0] oWeight_t_top,
  output logic                 oEnable_w,
  output logic                 oRun,
  output logic [WORD_SIZE-1:0] oIfmap_t_left,
  output logic                 oOut_valid,
  output logic                 oBusy,
  output logic                 oDone
);

  localparam int TAG_LEN   = 1 + NUM_PE * PE_LAT;
  localparam int DRAIN_LEN = NUM_PE * PE_LAT + 1;
  localparam int CW        = $clog2(NUM_PE + 1);
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, PRELOAD, STREAM, DRAIN, DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        w_cnt_reg;
  logic [DCW-1:0]       drain_cnt_reg;
  logic [TAG_LEN-1:0]   tag_reg;
  logic                 w_accept, x_accept, w_last, drain_end;

  assign w_accept  = (state_reg == LOAD_W) && iW_valid;
  assign x_accept  = (state_reg == STREAM) && iX_valid;
  assign w_last    = (w_cnt_reg == CW'(NUM_PE - 1));
  assign drain_end = (drain_cnt_reg == DCW'(DRAIN_LEN - 1));

  always_ff @(posedge iClk) begin
    if (iRest) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    oW_ready   = 1'b0;
    oX_ready   = 1'b0;
    oEnable_w  = 1'b0;
    oRun       = 1'b0;
    oBusy      = 1'b1;
    oDone      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) state_next = LOAD_W;
      end
      LOAD_W: begin
        oW_ready = 1'b1;
        if (w_accept && w_last) state_next = PRELOAD;
      end
      PRELOAD: begin
        oEnable_w  = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        oRun     = 1'b1;
        oX_ready = 1'b1;
        if (x_accept && iX_last) state_next = DRAIN;
      end
      DRAIN: begin
        oRun = 1'b1;
        if (drain_end) state_next = DONE;
      end
      DONE: begin
        oDone      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters clear whenever their state is not active, so every job starts fresh.
  always_ff @(posedge iClk) begin
    if (iRest) begin
      w_cnt_reg     <= '0;
      drain_cnt_reg <= '0;
      tag_reg       <= '0;
    end else begin
      if (state_reg != LOAD_W) w_cnt_reg <= '0;
      else if (w_accept)       w_cnt_reg <= w_cnt_reg + CW'(1);
      if (state_reg != DRAIN)  drain_cnt_reg <= '0;
      else                     drain_cnt_reg <= drain_cnt_reg + DCW'(1);
      tag_reg <= {tag_reg[TAG_LEN-2:0], x_accept};
    end
  end

  assign oOut_valid = tag_reg[TAG_LEN-1];

  // Lane gi owns its weight byte and a delay line of depth gi+1; non-accepted slots inject zeros.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] w_lane_reg;
      logic [DATA_WIDTH-1:0] skew_reg [0:gi];

      always_ff @(posedge iClk) begin
        if (iRest) begin
          w_lane_reg <= '0;
          for (int s = 0; s <= gi; s++) skew_reg[s] <= '0;
        end else begin
          if (w_accept && (w_cnt_reg == CW'(gi))) w_lane_reg <= iW_data;
          skew_reg[0] <= x_accept ? iX_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          for (int s = 1; s <= gi; s++) skew_reg[s] <= skew_reg[s-1];
        end
      end

      assign oWeight_t_top[gi*DATA_WIDTH +: DATA_WIDTH] = w_lane_reg;
      assign oIfmap_t_left[gi*DATA_WIDTH +: DATA_WIDTH] = skew_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_pe_array_feeder.sv
// Randomized scenario bench for pe_array_feeder against a cycle-history reference model.
module tb_pe_array_feeder;

  logic        iClk = 1'b0;
  logic        iRest = 1'b1, iStart = 1'b0, iW_valid = 1'b0, iX_valid = 1'b0, iX_last = 1'b0;
  logic [7:0]  iW_data = '0;
  logic [71:0] iX_data = '0;
  logic        oW_ready, oX_ready, oEnable_w, oRun, oOut_valid, oBusy, oDone;
  logic [71:0] oWeight_t_top, oIfmap_t_left;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  w_arr [9];
  logic [71:0] win_q [$];
  bit          sched_q [$];
  logic [71:0] inj_q [$];
  bit          acc_q [$];

  pe_array_feeder dut (
    .iClk(iClk), .iRest(iRest), .iStart(iStart),
    .iW_valid(iW_valid), .iW_data(iW_data), .oW_ready(oW_ready),
    .iX_valid(iX_valid), .iX_data(iX_data), .iX_last(iX_last), .oX_ready(oX_ready),
    .oWeight_t_top(oWeight_t_top), .oEnable_w(oEnable_w), .oRun(oRun),
    .oIfmap_t_left(oIfmap_t_left), .oOut_valid(oOut_valid), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [71:0] rand72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic test_reset();
    iRest = 1; iStart = 1; iW_valid = 1; iX_valid = 1; iX_data = rand72(); iW_data = 8'($urandom);
    repeat (3) tick();
    n_total++;
    if ({oW_ready, oX_ready, oEnable_w, oRun, oOut_valid, oBusy, oDone, oWeight_t_top, oIfmap_t_left} !== '0)
      $display("FAIL reset_outputs: got ctl=%b w=%h x=%h want all zero",
               {oW_ready, oX_ready, oEnable_w, oRun, oOut_valid, oBusy, oDone}, oWeight_t_top, oIfmap_t_left);
    else n_pass++;
    iRest = 0; iStart = 0; iW_valid = 0; iX_valid = 0;
    tick();
    n_total++;
    if ({oBusy, oW_ready, oX_ready, oRun} !== 4'b0000)
      $display("FAIL reset_release_idle: got %b want 0000", {oBusy, oW_ready, oX_ready, oRun});
    else n_pass++;
  endtask

  task automatic test_start_no_weights();
    iW_valid = 1; iX_valid = 1;
    tick();
    n_total++;
    if ({oW_ready, oX_ready} !== 2'b00)
      $display("FAIL idle_no_ready: got %b want 00", {oW_ready, oX_ready});
    else n_pass++;
    iW_valid = 0; iX_valid = 0; iStart = 1;
    tick();
    iStart = 0;
    repeat (4) begin
      n_total++;
      if ({oW_ready, oBusy, oEnable_w, oRun, oX_ready} !== 5'b11000)
        $display("FAIL load_w_wait_ctl: got %b want 11000", {oW_ready, oBusy, oEnable_w, oRun, oX_ready});
      else n_pass++;
      n_total++;
      if ({oOut_valid, oWeight_t_top, oIfmap_t_left} !== '0)
        $display("FAIL load_w_wait_data: got w=%h x=%h ov=%b want zero", oWeight_t_top, oIfmap_t_left, oOut_valid);
      else n_pass++;
      tick();
    end
    iRest = 1;
    tick();
    iRest = 0;
    n_total++;
    if (oBusy !== 1'b0) $display("FAIL load_w_reset: got busy=%b want 0", oBusy);
    else n_pass++;
  endtask

  // Runs one job from IDLE using w_arr, win_q and sched_q; abort_at >= 0 resets at that stream cycle.
  task automatic run_job(input int wgap_pct, input int abort_at);
    int k, s_len, nwin, ov_cnt, idx;
    logic [71:0] exp_w, exp_lanes, tmp;
    logic        exp_ov;
    logic [5:0]  exp_ctl;
    bit          sbit;
    inj_q.delete(); acc_q.delete();
    s_len = sched_q.size(); nwin = win_q.size(); ov_cnt = 0;
    exp_w = '0;
    for (int i = 0; i < 9; i++) exp_w = exp_w | (72'(w_arr[i]) << (8 * i));

    n_total++;
    if ({oBusy, oW_ready, oX_ready} !== 3'b000)
      $display("FAIL idle_before_start: got %b want 000", {oBusy, oW_ready, oX_ready});
    else n_pass++;
    iStart = 1;
    tick();

    k = 0;
    while (k < 9) begin
      n_total++;
      if ({oW_ready, oBusy, oEnable_w, oRun} !== 4'b1100)
        $display("FAIL load_w_ctl: got %b want 1100", {oW_ready, oBusy, oEnable_w, oRun});
      else n_pass++;
      iW_valid = ($urandom_range(99) >= wgap_pct);
      iW_data  = iW_valid ? w_arr[k] : 8'($urandom);
      iStart   = 1'($urandom);
      tick();
      if (iW_valid) k++;
    end
    iW_valid = 0;

    n_total++;
    if ({oW_ready, oX_ready, oEnable_w, oRun, oBusy, oDone} !== 6'b001010)
      $display("FAIL preload_ctl: got %b want 001010", {oW_ready, oX_ready, oEnable_w, oRun, oBusy, oDone});
    else n_pass++;
    n_total++;
    if (oWeight_t_top !== exp_w) $display("FAIL preload_weights: got %h want %h", oWeight_t_top, exp_w);
    else n_pass++;
    iStart = 1'($urandom);
    tick();

    for (int c = 0; c <= s_len + 11; c++) begin
      exp_lanes = '0;
      for (int l = 0; l < 9; l++) begin
        idx = c - 1 - l;
        if (idx >= 0 && idx < inj_q.size()) begin
          tmp = inj_q[idx];
          exp_lanes[8*l +: 8] = tmp[8*l +: 8];
        end
      end
      exp_ov  = (c >= 10 && (c - 10) < acc_q.size()) ? acc_q[c-10] : 1'b0;
      exp_ctl = {1'b0, c < s_len, 1'b0, c < s_len + 10, c <= s_len + 10, c == s_len + 10};

      n_total++;
      if (oIfmap_t_left !== exp_lanes) $display("FAIL lanes c=%0d: got %h want %h", c, oIfmap_t_left, exp_lanes);
      else n_pass++;
      n_total++;
      if (oOut_valid !== exp_ov) $display("FAIL out_valid c=%0d: got %b want %b", c, oOut_valid, exp_ov);
      else n_pass++;
      n_total++;
      if ({oW_ready, oX_ready, oEnable_w, oRun, oBusy, oDone} !== exp_ctl)
        $display("FAIL ctl c=%0d: got %b want %b", c, {oW_ready, oX_ready, oEnable_w, oRun, oBusy, oDone}, exp_ctl);
      else n_pass++;
      n_total++;
      if (oWeight_t_top !== exp_w) $display("FAIL weights_stable c=%0d: got %h want %h", c, oWeight_t_top, exp_w);
      else n_pass++;
      if (oOut_valid === 1'b1) ov_cnt++;

      if (c == abort_at) begin
        iRest = 1; iX_valid = 1; iX_data = rand72(); iStart = 0;
        tick();
        iRest = 0; iX_valid = 0; iW_valid = 0; iX_last = 0;
        n_total++;
        if ({oW_ready, oX_ready, oEnable_w, oRun, oOut_valid, oBusy, oDone, oWeight_t_top, oIfmap_t_left} !== '0)
          $display("FAIL abort_outputs: got ctl=%b w=%h x=%h want all zero",
                   {oW_ready, oX_ready, oEnable_w, oRun, oOut_valid, oBusy, oDone}, oWeight_t_top, oIfmap_t_left);
        else n_pass++;
        tick();
        n_total++;
        if ({oBusy, oRun, oX_ready, oOut_valid, oIfmap_t_left} !== '0)
          $display("FAIL abort_no_resume: got busy=%b run=%b xr=%b ov=%b x=%h want zero",
                   oBusy, oRun, oX_ready, oOut_valid, oIfmap_t_left);
        else n_pass++;
        sched_q.delete(); win_q.delete();
        return;
      end
      if (c == s_len + 11) break;

      if (c < s_len) begin
        sbit = sched_q.pop_front();
        iX_valid = sbit;
        if (sbit) begin
          iX_data = win_q.pop_front();
          iX_last = (win_q.size() == 0);
        end else begin
          iX_data = rand72();
          iX_last = 1'($urandom);
        end
        inj_q.push_back(sbit ? iX_data : 72'h0);
        acc_q.push_back(sbit);
      end else begin
        iX_valid = 1'($urandom); iX_data = rand72(); iX_last = 1'($urandom);
        inj_q.push_back(72'h0);
        acc_q.push_back(1'b0);
      end
      iW_valid = 1'($urandom); iW_data = 8'($urandom);
      iStart   = 1'($urandom);
      tick();
    end
    iStart = 0; iX_valid = 0; iW_valid = 0; iX_last = 0;
    n_total++;
    if (ov_cnt !== nwin) $display("FAIL out_valid_count: got %0d want %0d", ov_cnt, nwin);
    else n_pass++;
  endtask

  task automatic test_weight_and_skew();
    logic [71:0] win;
    for (int i = 0; i < 9; i++) w_arr[i] = 8'(i + 1);
    for (int i = 0; i < 9; i++) win[8*i +: 8] = 8'(8'h11 * (i + 1));
    win_q.push_back(win);
    sched_q.push_back(1'b1);
    run_job(40, -1);
    n_total++;
    if (oWeight_t_top !== 72'h090807060504030201)
      $display("FAIL packed_weights: got %h want 090807060504030201", oWeight_t_top);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 9; i++) w_arr[i] = 8'($urandom);
    repeat (4) win_q.push_back(rand72());
    sched_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    run_job(0, -1);
  endtask

  task automatic test_reset_mid_stream();
    for (int i = 0; i < 9; i++) w_arr[i] = 8'($urandom);
    repeat (4) win_q.push_back(rand72());
    sched_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    run_job(20, 3);
  endtask

  task automatic test_single_window();
    for (int i = 0; i < 9; i++) w_arr[i] = 8'($urandom);
    win_q.push_back(rand72());
    sched_q = '{1'b0, 1'b0, 1'b1};
    run_job(0, -1);
  endtask

  task automatic test_random_jobs();
    int nw;
    repeat (4) begin
      for (int i = 0; i < 9; i++) w_arr[i] = 8'($urandom);
      nw = $urandom_range(1, 8);
      for (int j = 0; j < nw; j++) begin
        while ($urandom_range(99) < 30) sched_q.push_back(1'b0);
        sched_q.push_back(1'b1);
        win_q.push_back(rand72());
      end
      run_job(30, -1);
    end
  endtask

  initial begin
    test_reset();
    test_start_no_weights();
    test_weight_and_skew();
    test_bubbles();
    test_reset_mid_stream();
    test_single_window();
    test_random_jobs();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
